// File: rtl/ex_alu_unit.sv
// rtl/ex_alu_unit.sv - MIPS execute stage: ALU-control decode, registered 32-bit ALU, PC/branch adder
// Decoder and adder are combinational; result/zero/overflow form one register stage.
module ex_alu_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  input  logic [31:0] add_a,
  input  logic [31:0] add_b,
  output logic [31:0] add_sum
);

  localparam logic [3:0] C_AND  = 4'd0;
  localparam logic [3:0] C_OR   = 4'd1;
  localparam logic [3:0] C_ADD  = 4'd2;
  localparam logic [3:0] C_ADDU = 4'd3;
  localparam logic [3:0] C_XOR  = 4'd4;
  localparam logic [3:0] C_NOR  = 4'd5;
  localparam logic [3:0] C_SUB  = 4'd6;
  localparam logic [3:0] C_SUBU = 4'd7;
  localparam logic [3:0] C_SLT  = 4'd8;
  localparam logic [3:0] C_SLTU = 4'd9;
  localparam logic [3:0] C_SLL  = 4'd10;
  localparam logic [3:0] C_SRL  = 4'd11;
  localparam logic [3:0] C_SRA  = 4'd12;
  localparam logic [3:0] C_SLLV = 4'd13;
  localparam logic [3:0] C_SRLV = 4'd14;
  localparam logic [3:0] C_SRAV = 4'd15;

  logic [3:0]  w_funct_ctrl;
  logic [3:0]  w_ctrl;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [4:0]  w_vshamt;
  logic        w_slt;
  logic        w_sltu;
  logic [31:0] w_result;
  logic        w_overflow;

  logic [31:0] r_result;
  logic        r_zero;
  logic        r_overflow;

  always_comb begin
    w_funct_ctrl = C_ADD;
    case (funct)
      6'b100000: w_funct_ctrl = C_ADD;
      6'b100001: w_funct_ctrl = C_ADDU;
      6'b100010: w_funct_ctrl = C_SUB;
      6'b100011: w_funct_ctrl = C_SUBU;
      6'b100100: w_funct_ctrl = C_AND;
      6'b100101: w_funct_ctrl = C_OR;
      6'b100110: w_funct_ctrl = C_XOR;
      6'b100111: w_funct_ctrl = C_NOR;
      6'b101010: w_funct_ctrl = C_SLT;
      6'b101011: w_funct_ctrl = C_SLTU;
      6'b000000: w_funct_ctrl = C_SLL;
      6'b000010: w_funct_ctrl = C_SRL;
      6'b000011: w_funct_ctrl = C_SRA;
      6'b000100: w_funct_ctrl = C_SLLV;
      6'b000110: w_funct_ctrl = C_SRLV;
      6'b000111: w_funct_ctrl = C_SRAV;
      default:   w_funct_ctrl = C_ADD;
    endcase
  end

  // ALUOp values above 0111 are unused by main control and fall back to ADD.
  always_comb begin
    w_ctrl = C_ADD;
    case (alu_op)
      4'b0000: w_ctrl = C_ADD;
      4'b0001: w_ctrl = C_SUB;
      4'b0010: w_ctrl = w_funct_ctrl;
      4'b0011: w_ctrl = C_AND;
      4'b0100: w_ctrl = C_OR;
      4'b0101: w_ctrl = C_SLT;
      4'b0110: w_ctrl = C_XOR;
      4'b0111: w_ctrl = C_ADDU;
      default: w_ctrl = C_ADD;
    endcase
  end

  assign alu_ctrl = w_ctrl;

  assign w_sum    = a + b;
  assign w_diff   = a - b;
  assign w_vshamt = a[4:0];
  assign w_slt    = ($signed(a) < $signed(b));
  assign w_sltu   = (a < b);

  always_comb begin
    w_result   = w_sum;
    w_overflow = 1'b0;
    case (w_ctrl)
      C_AND:  w_result = a & b;
      C_OR:   w_result = a | b;
      C_ADD: begin
        w_result   = w_sum;
        w_overflow = (a[31] == b[31]) && (w_sum[31] != a[31]);
      end
      C_ADDU: w_result = w_sum;
      C_XOR:  w_result = a ^ b;
      C_NOR:  w_result = ~(a | b);
      C_SUB: begin
        w_result   = w_diff;
        w_overflow = (a[31] != b[31]) && (w_diff[31] != a[31]);
      end
      C_SUBU: w_result = w_diff;
      C_SLT:  w_result = {31'd0, w_slt};
      C_SLTU: w_result = {31'd0, w_sltu};
      C_SLL:  w_result = b << shamt;
      C_SRL:  w_result = b >> shamt;
      C_SRA:  w_result = $unsigned($signed(b) >>> shamt);
      C_SLLV: w_result = b << w_vshamt;
      C_SRLV: w_result = b >> w_vshamt;
      C_SRAV: w_result = $unsigned($signed(b) >>> w_vshamt);
      default: begin
        w_result   = w_sum;
        w_overflow = 1'b0;
      end
    endcase
  end

  // No enable: stalls are applied by the upstream pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result   <= 32'd0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_result   <= w_result;
      r_zero     <= (w_result == 32'd0);
      r_overflow <= w_overflow;
    end
  end

  assign result   = r_result;
  assign zero     = r_zero;
  assign overflow = r_overflow;

  assign add_sum = add_a + add_b;

endmodule

// File: tb/tb_ex_alu_unit.sv
// tb/tb_ex_alu_unit.sv - scoreboard bench for ex_alu_unit against an arithmetic reference model
module tb_ex_alu_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;

  typedef struct {
    logic [31:0] res;
    logic        zr;
    logic        ov;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  ex_alu_unit dut (
    .clk(clk), .reset(reset), .alu_op(alu_op), .funct(funct), .shamt(shamt),
    .a(a), .b(b), .alu_ctrl(alu_ctrl), .result(result), .zero(zero),
    .overflow(overflow), .add_a(add_a), .add_b(add_b), .add_sum(add_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int ref_ctrl(input int op, input int fn);
    int lut_op[16] = '{2, 6, -1, 0, 1, 8, 4, 3, 2, 2, 2, 2, 2, 2, 2, 2};
    if (op != 2) return lut_op[op];
    case (fn)
      32: return 2;  33: return 3;  34: return 6;  35: return 7;
      36: return 0;  37: return 1;  38: return 4;  39: return 5;
      42: return 8;  43: return 9;
      0:  return 10; 2:  return 11; 3:  return 12;
      4:  return 13; 6:  return 14; 7:  return 15;
      default: return 2;
    endcase
  endfunction

  function automatic exp_t ref_alu(input int ctrl, input logic [31:0] ua, input logic [31:0] ub, input int sh);
    exp_t e;
    int sa = ua;
    int sb = ub;
    longint wide;
    int va = ua % 32;
    e.ov = 1'b0;
    case (ctrl)
      0: e.res = ua & ub;
      1: e.res = ua | ub;
      2: begin
        e.res = ua + ub;
        wide = longint'(sa) + longint'(sb);
        e.ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      3: e.res = ua + ub;
      4: e.res = ua ^ ub;
      5: e.res = ~(ua | ub);
      6: begin
        e.res = ua - ub;
        wide = longint'(sa) - longint'(sb);
        e.ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      7: e.res = ua - ub;
      8: e.res = (sa < sb) ? 1 : 0;
      9: e.res = (ua < ub) ? 1 : 0;
      10: e.res = ub << sh;
      11: e.res = ub >> sh;
      12: e.res = sb >>> sh;
      13: e.res = ub << va;
      14: e.res = ub >> va;
      default: e.res = sb >>> va;
    endcase
    e.zr = (e.res == 0);
    return e;
  endfunction

  // Drives one operation (caller aligns to the falling edge) and queues its expected capture.
  task automatic issue(input logic [3:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] va, input logic [31:0] vb);
    int c;
    alu_op = op; funct = fn; shamt = sh; a = va; b = vb;
    c = ref_ctrl(int'(op), int'(fn));
    q.push_back(ref_alu(c, va, vb, int'(sh)));
    #1;
    check("alu_ctrl", {28'd0, alu_ctrl}, c);
  endtask

  task automatic adder(input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp);
    add_a = x; add_b = y;
    #1;
    check("add_sum", add_sum, exp);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("result", result, e.res);
      check("zero", {31'd0, zero}, {31'd0, e.zr});
      check("overflow", {31'd0, overflow}, {31'd0, e.ov});
    end
  end

  function automatic logic [31:0] pick_operand();
    logic [31:0] sp[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  initial begin
    logic [5:0] fl[16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                           6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    reset = 1'b1; alu_op = 4'd0; funct = 6'd0; shamt = 5'd0;
    a = 32'd5; b = 32'd7; add_a = 32'd0; add_b = 32'd0;
    #2 reset = 1'b0;
    #1;
    check("rst_result_async", result, 32'd0);
    check("rst_zero_async", {31'd0, zero}, 32'd0);
    check("rst_ovf_async", {31'd0, overflow}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_result_hold", result, 32'd0);
      check("rst_zero_hold", {31'd0, zero}, 32'd0);
      check("rst_ovf_hold", {31'd0, overflow}, 32'd0);
    end
    reset = 1'b1;
    issue(4'b0000, 6'd0, 5'd0, 32'd5, 32'd7);
    @(negedge clk);
    check("first_after_reset", result, 32'd12);

    adder(32'h0000_0040, 32'd4, 32'h0000_0044);
    adder(32'hFFFF_FFFC, 32'd4, 32'h0000_0000);

    for (int i = 0; i < 16; i++) begin
      issue(4'b0010, fl[i], 5'd7, pick_operand(), pick_operand());
      @(negedge clk);
    end
    issue(4'b0010, 6'b111111, 5'd0, 32'd3, 32'd4); @(negedge clk);
    issue(4'b0000, 6'd0, 5'd0, 32'h7FFF_FFFF, 32'd1); @(negedge clk);
    issue(4'b0111, 6'd0, 5'd0, 32'h7FFF_FFFF, 32'd1); @(negedge clk);
    issue(4'b0001, 6'd0, 5'd0, 32'h1234, 32'h1234); @(negedge clk);
    issue(4'b0010, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1); @(negedge clk);
    issue(4'b0010, 6'h2B, 5'd0, 32'hFFFF_FFFF, 32'd1); @(negedge clk);
    issue(4'b0010, 6'h03, 5'd4, 32'd0, 32'h8000_0000); @(negedge clk);
    issue(4'b0010, 6'h02, 5'd4, 32'd0, 32'h8000_0000); @(negedge clk);
    issue(4'b0010, 6'h04, 5'd0, 32'h23, 32'd1); @(negedge clk);
    issue(4'b0001, 6'd0, 5'd0, 32'h8000_0000, 32'd1); @(negedge clk);
    for (int op = 8; op < 16; op++) begin
      issue(4'(op), 6'($urandom), 5'd0, pick_operand(), pick_operand());
      @(negedge clk);
    end

    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      logic [5:0] fn;
      logic [31:0] x, y;
      op = ($urandom_range(0, 1) == 0) ? 4'b0010 : 4'($urandom);
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fl[$urandom_range(0, 15)];
      issue(op, fn, 5'($urandom), pick_operand(), pick_operand());
      x = $urandom; y = $urandom;
      adder(x, y, 32'(longint'(x) + longint'(y)));
      @(negedge clk);
    end
    drain();

    issue(4'b0000, 6'd0, 5'd0, 32'd100, 32'd23);
    drain();
    alu_op = 4'b0000; a = 32'd9; b = 32'd9;
    #2 reset = 1'b0;
    #1;
    check("midop_reset_async", result, 32'd0);
    @(posedge clk); #1;
    check("midop_reset_discard", result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    issue(4'b0000, 6'd0, 5'd0, 32'd9, 32'd9);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
